// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding,
// ROM geometry and instruction width.
package fetch_pkg;

  localparam int unsigned ROM_WORDS = 32;
  localparam int unsigned ADDR_W    = $clog2(ROM_WORDS);
  localparam int unsigned INSTR_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Bundle of control, ROM and instruction-output signals of the fetch controller.
// The master side is the controller; the slave side is its environment.
interface instr_fetch_ctrl_if #(
  parameter int unsigned ADDR_W = fetch_pkg::ADDR_W
);
  import fetch_pkg::*;

  logic               start;
  logic               redirect_valid;
  logic [31:0]        redirect_addr;
  logic               instr_ready;
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_q;
  logic [INSTR_W-1:0] instr;
  logic [31:0]        instr_pc;
  logic               instr_valid;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    input  start, redirect_valid, redirect_addr, instr_ready, rom_q,
    output rom_addr, instr, instr_pc, instr_valid, busy, done, err
  );

  modport slave (
    output start, redirect_valid, redirect_addr, instr_ready, rom_q,
    input  rom_addr, instr, instr_pc, instr_valid, busy, done, err
  );

endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks an external combinational ROM from
// RESET_PC, honours redirects and back-pressure, stops at the last ROM word.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_WORDS = fetch_pkg::ROM_WORDS
) (
  input logic              clk,
  input logic              rst,
  instr_fetch_ctrl_if.master bus
);
  import fetch_pkg::*;

  localparam int unsigned AW   = $clog2(ROM_WORDS);
  localparam logic [AW-1:0] LAST = AW'(ROM_WORDS - 1);

  state_t             state, state_next;
  logic [31:0]        pc, pc_next;
  logic [INSTR_W-1:0] instr_hold, instr_hold_next;
  logic [31:0]        instr_pc_hold, instr_pc_hold_next;
  logic               valid, valid_next;
  logic               err_flag, err_flag_next;

  logic        slot_free;
  logic        redir_oob;
  logic [29:0] redir_word;
  logic        unused_addr_bits;

  assign slot_free        = !valid || bus.instr_ready;
  assign redir_word       = bus.redirect_addr[31:2];
  assign redir_oob        = redir_word >= 30'(ROM_WORDS);
  assign unused_addr_bits = ^bus.redirect_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      instr_hold    <= '0;
      instr_pc_hold <= '0;
      valid         <= 1'b0;
      err_flag      <= 1'b0;
    end else begin
      state         <= state_next;
      pc            <= pc_next;
      instr_hold    <= instr_hold_next;
      instr_pc_hold <= instr_pc_hold_next;
      valid         <= valid_next;
      err_flag      <= err_flag_next;
    end
  end

  always_comb begin
    state_next         = state;
    pc_next            = pc;
    instr_hold_next    = instr_hold;
    instr_pc_hold_next = instr_pc_hold;
    valid_next         = valid;
    err_flag_next      = err_flag;

    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_next    = ST_FETCH;
          pc_next       = RESET_PC;
          err_flag_next = 1'b0;
          valid_next    = 1'b0;
        end
      end

      ST_FETCH: begin
        // Redirect beats both fetch and stall: the pending entry is dropped
        // even when downstream is accepting it this cycle.
        if (bus.redirect_valid) begin
          valid_next = 1'b0;
          pc_next    = {redir_word, 2'b00};
          if (redir_oob) begin
            err_flag_next = 1'b1;
            state_next    = ST_DONE;
          end
        end else if (slot_free) begin
          instr_hold_next    = bus.rom_q;
          instr_pc_hold_next = pc;
          valid_next         = 1'b1;
          pc_next            = pc + 32'd4;
          if (pc[AW+1:2] == LAST) begin
            state_next = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (bus.start) begin
          state_next    = ST_FETCH;
          pc_next       = RESET_PC;
          err_flag_next = 1'b0;
          valid_next    = 1'b0;
        end else if (valid && bus.instr_ready) begin
          valid_next = 1'b0;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.rom_addr    = pc[AW+1:2];
  assign bus.instr       = instr_hold;
  assign bus.instr_pc    = instr_pc_hold;
  assign bus.instr_valid = valid;
  assign bus.busy        = (state == ST_FETCH);
  assign bus.done        = (state == ST_DONE);
  assign bus.err         = err_flag;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl: the expected instruction stream is
// queued when starts/redirects are issued, and a monitor checks accepted beats.
module tb_instr_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int unsigned NW  = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_ctrl_if bus ();

  instr_fetch_ctrl #(.RESET_PC(RPC), .ROM_WORDS(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] rom [NW];
  assign bus.rom_q = rom[bus.rom_addr];

  beat_t q[$];
  beat_t mon_exp;
  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Expected stream: sequential words from a byte address to the ROM end.
  function automatic void push_stream(input logic [31:0] from);
    q.delete();
    for (int unsigned w = from >> 2; w < NW; w++) q.push_back('{pc: 32'(w * 4), ins: rom[w]});
  endfunction

  // A beat is consumed when valid and ready meet on an edge without a redirect.
  always @(negedge clk) begin
    if (!rst && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got pc %h expected no beat", bus.instr_pc);
      end else begin
        mon_exp = q.pop_front();
        chk("beat_pc", bus.instr_pc, mon_exp.pc);
        chk("beat_instr", bus.instr, mon_exp.ins);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pc(input logic [31:0] pc);
    int n = 0;
    while (!(bus.instr_valid && bus.instr_pc == pc) && n < 100) begin
      step();
      n++;
    end
    chk("wait_pc_reached", bus.instr_pc, pc);
  endtask

  task automatic issue_start();
    bus.start = 1'b1;
    push_stream(RPC);
    step();
    bus.start = 1'b0;
  endtask

  task automatic drain(input int redirs);
    int n = 0;
    int left = redirs;
    logic [31:0] tgt;
    while (!(bus.done && !bus.instr_valid) && n < 600) begin
      bus.instr_ready = 1'($urandom_range(0, 1));
      if (left > 0 && bus.busy && $urandom_range(0, 9) == 0) begin
        tgt = 32'($urandom_range(0, NW - 1) * 4) | 32'($urandom_range(0, 3));
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = tgt;
        push_stream(tgt & ~32'd3);
        left--;
      end
      step();
      bus.redirect_valid = 1'b0;
      n++;
    end
    chk("drain_done", 32'(bus.done), 32'd1);
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int n;
    for (int unsigned i = 0; i < NW; i++) rom[i] = $urandom;
    bus.start          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    bus.instr_ready    = 1'b0;

    // Reset state and a full run with ready held high.
    rst = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_instr_pc", bus.instr_pc, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'(RPC[6:2]));
    rst = 1'b0;
    step();
    bus.instr_ready = 1'b1;
    issue_start();
    chk("start_busy", 32'(bus.busy), 32'd1);
    chk("start_valid_lat", 32'(bus.instr_valid), 32'd0);
    step();
    chk("first_valid", 32'(bus.instr_valid), 32'd1);
    chk("first_pc", bus.instr_pc, RPC);
    chk("first_instr", bus.instr, rom[0]);
    n = 0;
    while (!bus.done && n < 100) begin
      step();
      n++;
    end
    chk("run_cycles", 32'(n), 32'd31);
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_last_pc", bus.instr_pc, 32'h7C);
    for (int i = 0; i < 3; i++) step();
    chk("end_done", 32'(bus.done), 32'd1);
    chk("end_valid", 32'(bus.instr_valid), 32'd0);
    chk("end_queue_empty", 32'(q.size()), 32'd0);

    // Stall at 0x08 for three cycles.
    issue_start();
    wait_pc(32'h08);
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", bus.instr_pc, 32'h08);
      chk("stall_instr", bus.instr, rom[2]);
      chk("stall_rom_addr", 32'(bus.rom_addr), 32'd3);
    end
    bus.instr_ready = 1'b1;
    step();
    chk("release_pc", bus.instr_pc, 32'h0C);
    chk("release_valid", 32'(bus.instr_valid), 32'd1);
    drain(0);

    // Redirect to 0x41 while the 0x10 entry is held.
    bus.instr_ready = 1'b1;
    issue_start();
    wait_pc(32'h10);
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h41;
    push_stream(32'h40);
    step();
    bus.redirect_valid = 1'b0;
    chk("redir_flush", 32'(bus.instr_valid), 32'd0);
    chk("redir_rom_addr", 32'(bus.rom_addr), 32'd16);
    step();
    chk("redir_pc", bus.instr_pc, 32'h40);
    chk("redir_instr", bus.instr, rom[16]);
    drain(0);

    // Redirect together with ready on a valid beat.
    bus.instr_ready = 1'b1;
    issue_start();
    wait_pc(32'h20);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h08;
    push_stream(32'h08);
    step();
    bus.redirect_valid = 1'b0;
    chk("simul_flush", 32'(bus.instr_valid), 32'd0);
    drain(0);

    // Out-of-range redirect, then restart.
    bus.instr_ready = 1'b1;
    issue_start();
    wait_pc(32'h0C);
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h200;
    q.delete();
    step();
    bus.redirect_valid = 1'b0;
    chk("oob_flush", 32'(bus.instr_valid), 32'd0);
    chk("oob_err", 32'(bus.err), 32'd1);
    chk("oob_done", 32'(bus.done), 32'd1);
    chk("oob_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 3; i++) step();
    chk("oob_err_sticky", 32'(bus.err), 32'd1);
    issue_start();
    chk("restart_err", 32'(bus.err), 32'd0);
    chk("restart_busy", 32'(bus.busy), 32'd1);
    step();
    chk("restart_pc", bus.instr_pc, RPC);
    chk("restart_valid", 32'(bus.instr_valid), 32'd1);
    drain(0);

    // Reset in the middle of a run.
    bus.instr_ready = 1'b1;
    issue_start();
    wait_pc(32'h14);
    rst = 1'b1;
    q.delete();
    step();
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_valid", 32'(bus.instr_valid), 32'd0);
    chk("midrst_rom_addr", 32'(bus.rom_addr), 32'd0);
    issue_start();
    chk("midrst_restart_busy", 32'(bus.busy), 32'd1);
    drain(0);

    // Random back-pressure and random in-range redirects.
    for (int r = 0; r < 4; r++) begin
      issue_start();
      drain(3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address where fetch starts on each start pulse.
REQ-002 Parameter ROM_WORDS, default 32: instruction ROM depth in 32-bit words; the word-address width is log2(ROM_WORDS), which is 5 at the default.
REQ-003 Clock and reset are decided: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begins a fetch run from RESET_PC; honoured in IDLE and DONE only.
REQ-007 redirect_valid  in  1  branch/jump redirect request; honoured in FETCH only.
REQ-008 redirect_addr  in  32  redirect byte address; bits [1:0] are ignored.
REQ-009 instr_ready  in  1  downstream accepts instr this cycle.
REQ-010 rom_addr  out  5  word address to the instruction ROM; equals pc[6:2], combinational from the pc register.
REQ-011 rom_q  in  32  ROM read data; combinational, valid in the same cycle as rom_addr.
REQ-012 instr  out  32  registered instruction.
REQ-013 instr_pc  out  32  byte address of instr.
REQ-014 instr_valid  out  1  instr/instr_pc hold a valid entry.
REQ-015 busy  out  1  high in FETCH.
REQ-016 done  out  1  high in DONE.
REQ-017 err  out  1  sticky flag: a redirect targeted a word outside the ROM; cleared by start or rst.

Function
REQ-018 States: IDLE, FETCH, DONE; encoded as 2 bits.
REQ-019 IDLE + start -> FETCH; pc <= RESET_PC.
REQ-020 The output slot is free when instr_valid=0 or instr_ready=1; a free slot in FETCH is a fetch cycle.
- instr <= rom_q; instr_pc <= pc; instr_valid <= 1; pc <= pc+4.
REQ-021 In FETCH with instr_valid=1 and instr_ready=0 (stall), pc, instr, instr_pc and instr_valid hold.
REQ-022 If instr_valid=1, instr_ready=1 and no fetch occurs, instr_valid <= 0.
REQ-023 Latency: start sampled at edge N gives instr = ROM[RESET_PC>>2] with instr_valid=1 after edge N+1; with ready held high, one instruction per cycle thereafter.
REQ-024 Redirect in FETCH has priority over fetch and stall.
- instr_valid <= 0 (flush), regardless of instr_ready.
- pc <= {redirect_addr[31:2],2'b00}.
- No ROM word is captured that cycle.
REQ-025 Redirect target word >= ROM_WORDS -> flush, err <= 1, state -> DONE.
REQ-026 End of ROM: a fetch from the last word (pc[6:2]=ROM_WORDS-1) moves the state to DONE.
- The pc does not wrap.
- The captured instruction stays valid until accepted.
REQ-027 In DONE no fetch occurs; instr_valid clears on instr_ready; redirect_valid is ignored.
REQ-028 DONE + start -> FETCH; pc <= RESET_PC; err <= 0; instr_valid <= 0 (flush).
REQ-029 start in FETCH is ignored.
REQ-030 pc arithmetic is 32-bit modulo 2^32; only bits [6:2] drive rom_addr.

Reset
REQ-031 rst has priority over all inputs and aborts any run mid-operation.
REQ-032 Reset values:
- state = IDLE; pc = RESET_PC.
- instr = 0; instr_pc = 0; instr_valid = 0.
- busy = 0; done = 0; err = 0.
REQ-033 The cycle after rst deasserts is IDLE; start is honoured then.

Structure
REQ-034 Shared package fetch_pkg holds the state typedef/encoding, ROM_WORDS, the word-address width and the instruction width.
REQ-035 No sub-module: the pc register, next-pc mux and output register sit in one module.
REQ-036 reg_rom stays external; the bench connects rom_addr and rom_q to it.

Verification
REQ-037 Run from reset, ready always high: rst for 2 cycles, start pulse.
- Required: 32 consecutive instr_valid beats, instr_pc 0x00..0x7C, instr equal to ROM words 0..31.
- Then done=1, busy=0, no wrap to word 0.
REQ-038 Stall: hold instr_ready=0 for 3 cycles at instr_pc=0x08.
- Required: instr/instr_pc frozen, rom_addr=3.
- On release, next beat is instr_pc=0x0C; no beat lost or duplicated.
REQ-039 Redirect: redirect_valid with redirect_addr=0x41 while instr_pc=0x10 is valid.
- Required: that entry is flushed; the next valid beat is instr_pc=0x40 with ROM word 16.
REQ-040 Out-of-range redirect to 0x200.
- Required: flush, err=1, done=1.
- A following start clears err and restarts at 0x00.
REQ-041 Reset mid-run: rst asserted at instr_pc=0x14.
- Required: next cycle state IDLE, instr_valid=0, rom_addr=0.
- A start after rst restarts cleanly.
REQ-042 Simultaneous events: redirect_valid and instr_ready both high on a valid beat.
- Required: redirect wins; the pending beat is not re-presented.
